// File: rtl/alu_csr_responder_pkg.sv
// rtl/alu_csr_responder_pkg.sv - widths, opcodes, CSR bit indices and FSM states for the ALU CSR responder
package alu_csr_responder_pkg;

    localparam int ALUOPBITS     = 4;
    localparam int ALUDATABITS   = 32;
    localparam int ALUCSRINBITS  = 3;
    localparam int ALUCSROUTBITS = 3;

    localparam logic [ALUOPBITS-1:0] ALUOP_ADD   = 4'd0;
    localparam logic [ALUOPBITS-1:0] ALUOP_SUB   = 4'd1;
    localparam logic [ALUOPBITS-1:0] ALUOP_AND   = 4'd2;
    localparam logic [ALUOPBITS-1:0] ALUOP_OR    = 4'd3;
    localparam logic [ALUOPBITS-1:0] ALUOP_XOR   = 4'd4;
    localparam logic [ALUOPBITS-1:0] ALUOP_SLL   = 4'd5;
    localparam logic [ALUOPBITS-1:0] ALUOP_SRL   = 4'd6;
    localparam logic [ALUOPBITS-1:0] ALUOP_SRA   = 4'd7;
    localparam logic [ALUOPBITS-1:0] ALUOP_SLT   = 4'd8;
    localparam logic [ALUOPBITS-1:0] ALUOP_SLTU  = 4'd9;
    localparam logic [ALUOPBITS-1:0] ALUOP_MUL   = 4'd10;
    localparam logic [ALUOPBITS-1:0] ALUOP_MULHU = 4'd11;

    localparam int CSR_IN_ACK    = 0;
    localparam int CSR_IN_OP1    = 1;
    localparam int CSR_IN_OP2    = 2;
    localparam int CSR_OUT_RDY1  = 0;
    localparam int CSR_OUT_RDY2  = 1;
    localparam int CSR_OUT_VALID = 2;

    typedef enum logic [2:0] {
        ST_RDY_OP1,
        ST_RDY_OP2,
        ST_EXEC,
        ST_DONE,
        ST_RELEASE
    } state_t;

    function automatic logic [ALUCSROUTBITS-1:0] csr_flag(input int idx);
        logic [ALUCSROUTBITS-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/alu_csr_responder_alu_core.sv
// rtl/alu_csr_responder_alu_core.sv - combinational ALU; opcodes 10/11 need macro ALU_MUL_EN, else they yield 0
module alu_core
    import alu_csr_responder_pkg::*;
(
    input  logic [ALUOPBITS-1:0]   aluop,
    input  logic [ALUDATABITS-1:0] op1,
    input  logic [ALUDATABITS-1:0] op2,
    output logic [ALUDATABITS-1:0] result
);

    logic [4:0] shamt;
    assign shamt = op2[4:0];

`ifdef ALU_MUL_EN
    logic [2*ALUDATABITS-1:0] product;
    assign product = {{ALUDATABITS{1'b0}}, op1} * {{ALUDATABITS{1'b0}}, op2};
`endif

    always_comb begin
        result = '0;
        case (aluop)
            ALUOP_ADD:   result = op1 + op2;
            ALUOP_SUB:   result = op1 - op2;
            ALUOP_AND:   result = op1 & op2;
            ALUOP_OR:    result = op1 | op2;
            ALUOP_XOR:   result = op1 ^ op2;
            ALUOP_SLL:   result = op1 << shamt;
            ALUOP_SRL:   result = op1 >> shamt;
            ALUOP_SRA:   result = $unsigned($signed(op1) >>> shamt);
            ALUOP_SLT:   result = {{(ALUDATABITS-1){1'b0}}, $signed(op1) < $signed(op2)};
            ALUOP_SLTU:  result = {{(ALUDATABITS-1){1'b0}}, op1 < op2};
`ifdef ALU_MUL_EN
            ALUOP_MUL:   result = product[ALUDATABITS-1:0];
            ALUOP_MULHU: result = product[2*ALUDATABITS-1:ALUDATABITS];
`endif
            default:     result = '0;
        endcase
    end

endmodule

// File: rtl/alu_csr_responder.sv
// rtl/alu_csr_responder.sv - CSR-handshake ALU offload responder; multiply opcodes gated by macro ALU_MUL_EN
module alu_csr_responder
    import alu_csr_responder_pkg::*;
#(
    parameter int unsigned LATENCY = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ALUDATABITS-1:0]   OP1,
    input  logic [ALUDATABITS-1:0]   OP2,
    input  logic [ALUOPBITS-1:0]     ALUOP,
    input  logic [ALUCSRINBITS-1:0]  CSR_ALU_IN,
    output logic [ALUCSROUTBITS-1:0] CSR_ALU_OUT,
    output logic [ALUDATABITS-1:0]   OP3
);

    localparam logic [3:0] LAT_LOAD = 4'(LATENCY);

    state_t                 state;
    logic [ALUDATABITS-1:0] op1_q;
    logic [ALUDATABITS-1:0] op2_q;
    logic [ALUOPBITS-1:0]   aluop_q;
    logic [3:0]             cnt;
    logic [ALUDATABITS-1:0] alu_result;

    logic ack, stb_op1, stb_op2;
    assign ack     = CSR_ALU_IN[CSR_IN_ACK];
    assign stb_op1 = CSR_ALU_IN[CSR_IN_OP1];
    assign stb_op2 = CSR_ALU_IN[CSR_IN_OP2];

    alu_core u_alu_core (
        .aluop  (aluop_q),
        .op1    (op1_q),
        .op2    (op2_q),
        .result (alu_result)
    );

    // CSR_ALU_OUT is computed from the next state so each ready/valid bit moves on the same edge as the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_RDY_OP1;
            op1_q       <= '0;
            op2_q       <= '0;
            aluop_q     <= '0;
            cnt         <= '0;
            OP3         <= '0;
            CSR_ALU_OUT <= '0;
        end else begin
            case (state)
                ST_RDY_OP1: begin
                    if (stb_op1) begin
                        op1_q       <= OP1;
                        state       <= ST_RDY_OP2;
                        CSR_ALU_OUT <= csr_flag(CSR_OUT_RDY2);
                    end else begin
                        CSR_ALU_OUT <= csr_flag(CSR_OUT_RDY1);
                    end
                end
                ST_RDY_OP2: begin
                    if (stb_op2) begin
                        op2_q       <= OP2;
                        aluop_q     <= ALUOP;
                        cnt         <= LAT_LOAD;
                        state       <= ST_EXEC;
                        CSR_ALU_OUT <= '0;
                    end else begin
                        CSR_ALU_OUT <= csr_flag(CSR_OUT_RDY2);
                    end
                end
                ST_EXEC: begin
                    // Terminal count is 1 so that a load of LATENCY yields valid exactly LATENCY edges later.
                    if (cnt <= 4'd1) begin
                        OP3         <= alu_result;
                        cnt         <= '0;
                        state       <= ST_DONE;
                        CSR_ALU_OUT <= csr_flag(CSR_OUT_VALID);
                    end else begin
                        cnt         <= cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    if (ack) begin
                        state       <= ST_RELEASE;
                        CSR_ALU_OUT <= '0;
                    end else begin
                        CSR_ALU_OUT <= csr_flag(CSR_OUT_VALID);
                    end
                end
                ST_RELEASE: begin
                    if (!ack) begin
                        state       <= ST_RDY_OP1;
                        CSR_ALU_OUT <= csr_flag(CSR_OUT_RDY1);
                    end
                end
                default: begin
                    state       <= ST_RDY_OP1;
                    CSR_ALU_OUT <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_csr_responder.sv
// tb/tb_alu_csr_responder.sv - scoreboard bench for alu_csr_responder; multiply expectations follow macro ALU_MUL_EN
module tb_alu_csr_responder;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] OP1, OP2, OP3;
    logic [3:0]  ALUOP;
    logic [2:0]  CSR_ALU_IN, CSR_ALU_OUT;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];
    logic        prev_valid = 1'b0;

    alu_csr_responder #(.LATENCY(LAT)) dut (
        .clk         (clk),
        .reset       (reset),
        .OP1         (OP1),
        .OP2         (OP2),
        .ALUOP       (ALUOP),
        .CSR_ALU_IN  (CSR_ALU_IN),
        .CSR_ALU_OUT (CSR_ALU_OUT),
        .OP3         (OP3)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        int unsigned        sh;
`ifdef ALU_MUL_EN
        logic [63:0]        p;
        p = 64'(a) * 64'(b);
`endif
        sa = a;
        sh = b % 32;
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return a << sh;
            4'd6:  return a >> sh;
            4'd7:  return 32'(sa >>> sh);
            4'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:  return (a < b) ? 32'd1 : 32'd0;
`ifdef ALU_MUL_EN
            4'd10: return p[31:0];
            4'd11: return p[63:32];
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every rising edge of result-valid consumes one expected result.
    always @(negedge clk) begin
        if (CSR_ALU_OUT[2] && !prev_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: got valid with OP3=%h, expected no result at %0t", OP3, $time);
            end else begin
                check("op3_result", OP3, exp_q.pop_front());
            end
        end
        prev_valid = CSR_ALU_OUT[2];
    end

    task automatic send_op1(input logic [31:0] a);
        check("rdy_op1", 32'(CSR_ALU_OUT), 32'b001);
        OP1 = a;
        CSR_ALU_IN = 3'b010;
        tick();
        CSR_ALU_IN = 3'b000;
        OP1 = $urandom;
        check("rdy_op2", 32'(CSR_ALU_OUT), 32'b010);
    endtask

    task automatic send_op2(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                            input bit early_ack, input bit junk);
        logic [31:0] exp;
        exp = model(op, a, b);
        OP2 = b;
        ALUOP = op;
        CSR_ALU_IN = 3'b100;
        exp_q.push_back(exp);
        tick();
        CSR_ALU_IN = {2'b00, early_ack};
        OP2 = $urandom;
        ALUOP = 4'($urandom);
        for (int k = 0; k < LAT - 1; k++) begin
            check("exec_busy", 32'(CSR_ALU_OUT), 32'b000);
            if (junk) begin
                CSR_ALU_IN[2:1] = 2'($urandom);
                OP1 = $urandom;
                OP2 = $urandom;
            end
            tick();
        end
        CSR_ALU_IN[2:1] = 2'b00;
        tick();
        check("valid_latency", 32'(CSR_ALU_OUT), 32'b100);
        check("op3_at_valid", OP3, exp);
        if (!early_ack) begin
            int d;
            d = $urandom_range(0, 2);
            for (int k = 0; k < d; k++) begin
                tick();
                check("valid_held", 32'(CSR_ALU_OUT), 32'b100);
            end
            CSR_ALU_IN[0] = 1'b1;
        end
        tick();
        check("ack_drop", 32'(CSR_ALU_OUT), 32'b000);
        CSR_ALU_IN[0] = 1'b0;
        tick();
        check("release_rdy1", 32'(CSR_ALU_OUT), 32'b001);
        check("op3_hold", OP3, exp);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                          input bit early_ack, input bit junk);
        send_op1(a);
        send_op2(a, b, op, early_ack, junk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        OP1 = '0;
        OP2 = '0;
        ALUOP = '0;
        CSR_ALU_IN = '0;
        tick(); tick(); tick();
        check("reset_csr_out", 32'(CSR_ALU_OUT), 32'b000);
        check("reset_op3", OP3, 32'd0);
        reset = 1'b0;
        tick();
        check("post_reset_csr_out", 32'(CSR_ALU_OUT), 32'b001);
        check("post_reset_op3", OP3, 32'd0);

        run_op(32'd5, 32'd7, 4'd0, 1'b0, 1'b0);
        run_op(32'd0, 32'd1, 4'd1, 1'b0, 1'b0);
        run_op(32'h8000_0000, 32'd31, 4'd7, 1'b1, 1'b0);
        run_op(32'hFFFF_FFFF, 32'd1, 4'd8, 1'b0, 1'b1);
        run_op(32'hFFFF_FFFF, 32'd1, 4'd9, 1'b1, 1'b1);
        run_op(32'h0001_0000, 32'h0001_0000, 4'd10, 1'b0, 1'b0);
        run_op(32'h0001_0000, 32'h0001_0000, 4'd11, 1'b0, 1'b0);
        run_op(32'h1234_5678, 32'h9ABC_DEF0, 4'd13, 1'b0, 1'b0);

        // Mismatched and simultaneous strobes in RDY_OP1.
        OP2 = 32'hDEAD_BEEF;
        CSR_ALU_IN = 3'b100;
        tick();
        CSR_ALU_IN = 3'b000;
        check("op2_strobe_ignored", 32'(CSR_ALU_OUT), 32'b001);
        OP1 = 32'd100;
        OP2 = 32'd999;
        ALUOP = 4'd0;
        CSR_ALU_IN = 3'b110;
        tick();
        CSR_ALU_IN = 3'b000;
        check("simul_only_op1", 32'(CSR_ALU_OUT), 32'b010);
        tick();
        check("waits_fresh_op2", 32'(CSR_ALU_OUT), 32'b010);
        send_op2(32'd100, 32'd23, 4'd0, 1'b0, 1'b1);

        // Reset in the middle of EXEC abandons the operation.
        send_op1(32'd40);
        OP2 = 32'd2;
        ALUOP = 4'd0;
        CSR_ALU_IN = 3'b100;
        tick();
        CSR_ALU_IN = 3'b000;
        tick();
        reset = 1'b1;
        tick();
        check("midexec_reset_csr", 32'(CSR_ALU_OUT), 32'b000);
        check("midexec_reset_op3", OP3, 32'd0);
        reset = 1'b0;
        tick();
        check("midexec_post_reset", 32'(CSR_ALU_OUT), 32'b001);
        for (int k = 0; k < LAT + 2; k++) begin
            tick();
            check("no_valid_after_reset", 32'(CSR_ALU_OUT), 32'b001);
        end

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            case ($urandom_range(0, 3))
                0: begin a = $urandom; b = $urandom; end
                1: begin a = $urandom_range(0, 20); b = $urandom_range(0, 40); end
                2: begin a = 32'h8000_0000 ^ 32'($urandom_range(0, 3)); b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3)); end
                default: begin a = $urandom; b = 32'($urandom_range(0, 31)); end
            endcase
            run_op(a, b, 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
        end

        tick();
        tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
